ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 SHALL have ports, in order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  word-aligned fetch address.
- mem_rsp_valid  in  1  response valid; always accepted.
- mem_rsp_data  in  32  fetched instruction word.
- mem_rsp_err  in  1  access fault for this response.
- inst_valid  out  1  instruction available to decoder.
- inst_ready  in  1  decoder consumes instruction.
- inst  out  32  instruction word.
- inst_pc  out  32  address of inst.
- inst_fault  out  1  inst came from a faulted access.
- redirect_valid  in  1  control-flow redirect.
- redirect_pc  in  32  redirect target.

Function
REQ-004 SHALL implement states REQ (mem_req_valid=1), WAIT (one request outstanding), DROP (outstanding response to be discarded), HALT (fetch stopped after fault).
REQ-005 SHALL allow at most one outstanding request; request handshake = mem_req_valid & mem_req_ready.
REQ-006 SHALL assert mem_req_valid in REQ only when buffer count + outstanding < DEPTH; mem_req_addr = fetch PC with bits[1:0]=0.
REQ-007 SHALL hold mem_req_addr stable while mem_req_valid=1 and not handshaken.
REQ-008 REQ: on handshake -> WAIT. WAIT: on mem_rsp_valid push {pc, data, err} into buffer, PC += 4, -> REQ, or -> HALT if err.
REQ-009 SHALL push faulted entries with inst=32'h0000_0013 (NOP), inst_fault=1.
REQ-010 SHALL present buffer head registered: response accepted cycle N -> inst_valid at N+1 at the earliest.
REQ-011 SHALL pop head on inst_valid & inst_ready; inst, inst_pc, inst_fault stable while inst_valid=1 and not popped.
REQ-012 Push and pop in the same cycle SHALL both take effect; buffer never overflows (guaranteed by REQ-006).
REQ-013 redirect_valid SHALL flush buffer, set PC = {redirect_pc[31:2],2'b00}, and win over a same-cycle pop/push.
REQ-014 Redirect in REQ with same-cycle handshake, or in WAIT without same-cycle mem_rsp_valid -> DROP; in WAIT with same-cycle mem_rsp_valid -> response discarded, -> REQ; in REQ without handshake, or in HALT -> REQ.
REQ-015 DROP: redirect updates PC, stays DROP; mem_rsp_valid discarded -> REQ.
REQ-016 SHALL set inst_valid=0 in the cycle after a redirect.
REQ-017 PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 -> 0).

Reset
REQ-018 While reset=1: state REQ, PC=RESET_PC, buffer empty, no outstanding; mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0.
REQ-019 Reset asserted mid-transaction SHALL abandon it; a later response is ignored unless in WAIT/DROP.
REQ-020 First cycle after reset deasserts SHALL drive mem_req_valid=1, mem_req_addr=RESET_PC.

Configuration
REQ-021 With IFU_PREDECODE_EN defined: a non-faulted response with opcode 7'b1101111 (JAL) SHALL set next PC = pc + sign-extended J-immediate instead of pc+4.
REQ-022 Without IFU_PREDECODE_EN: next PC is always pc+4; no predecode logic present.

Structure
REQ-023 OPCODE_JAL and INST_NOP SHALL live in package inst_defines; state enum and IFU_W constants in package ifu_defines.
REQ-024 Buffer SHALL be sub-module ifu_fifo (DEPTH entries, push/pop/flush, count).

Verification
REQ-025 Reset release, mem_req_ready=1, 1-cycle response latency -> requests to 8000_0000, 8000_0004, 8000_0008; inst_pc matches in order.
REQ-026 inst_ready=0 for 10 cycles -> exactly DEPTH entries buffered, mem_req_valid=0, no request lost or duplicated.
REQ-027 Redirect to 0000_1003 while WAIT -> stale response discarded, next mem_req_addr=0000_1000, inst_valid=0 next cycle.
REQ-028 mem_rsp_err=1 at 8000_0004 -> inst=0000_0013, inst_fault=1, no further requests until redirect.
REQ-029 With IFU_PREDECODE_EN, 0080_006F (jal x0,+8) at 8000_0000 -> next mem_req_addr=8000_0008; without -> 8000_0004.
REQ-030 Reset asserted in WAIT, response arrives in reset cycle -> no entry pushed, restart at RESET_PC.

Source files
------------

// File: rtl/ifu_defines.sv
// ifu_defines: fetch-unit widths, FSM state encoding and the instruction buffer entry layout.
package ifu_defines;
    localparam int IFU_W = 32;
    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP, ST_HALT} ifu_state_e;
    typedef struct packed {
        logic [IFU_W-1:0] pc;
        logic [IFU_W-1:0] inst;
        logic             fault;
    } ifu_entry_t;
    localparam int IFU_ENTRY_W = $bits(ifu_entry_t);
endpackage

// File: rtl/inst_defines.sv
// inst_defines: RISC-V instruction encodings the fetch unit needs to recognise or synthesise.
package inst_defines;
    localparam logic [6:0]  OPCODE_JAL = 7'b1101111;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: power-of-two instruction buffer with push/pop/flush; head reads zero when empty.
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 65
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;
    assign do_push = push && (count_q != (AW+1)'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    assign dout  = (count_q != '0) ? mem_q[rd_q] : '0;
    assign count = count_q;
endmodule

// File: rtl/ifu.sv
// ifu: single-outstanding instruction fetch unit feeding a registered instruction buffer.
// Define IFU_PREDECODE_EN to follow JAL targets at fetch time instead of pc+4.
module ifu
    import ifu_defines::*;
    import inst_defines::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    ifu_state_e       state_q, state_d;
    logic [IFU_W-1:0] pc_q, pc_d, seq_pc;
    logic             hs, push, pop;
    logic [CW-1:0]    count;
    ifu_entry_t       head, entry;

    assign hs            = mem_req_valid && mem_req_ready;
    assign push          = (state_q == ST_WAIT) && mem_rsp_valid && !redirect_valid;
    assign pop           = inst_valid && inst_ready;
    // REQ state implies nothing outstanding, so only buffer occupancy limits issue
    assign mem_req_valid = !reset && (state_q == ST_REQ) && (count < CW'(DEPTH));
    assign mem_req_addr  = pc_q & ~32'h3;
    assign entry         = '{pc: mem_req_addr, inst: mem_rsp_err ? INST_NOP : mem_rsp_data, fault: mem_rsp_err};

`ifdef IFU_PREDECODE_EN
    logic [IFU_W-1:0] jimm;
    assign jimm   = {{12{mem_rsp_data[31]}}, mem_rsp_data[19:12], mem_rsp_data[20], mem_rsp_data[30:21], 1'b0};
    assign seq_pc = (!mem_rsp_err && mem_rsp_data[6:0] == OPCODE_JAL) ? pc_q + jimm : pc_q + 32'd4;
`else
    assign seq_pc = pc_q + 32'd4;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = redirect_valid ? (redirect_pc & ~32'h3) : push ? seq_pc : pc_q;
        unique case (state_q)
            ST_REQ:  state_d = hs ? (redirect_valid ? ST_DROP : ST_WAIT) : ST_REQ;
            ST_WAIT: state_d = !mem_rsp_valid ? (redirect_valid ? ST_DROP : ST_WAIT)
                                              : (!redirect_valid && mem_rsp_err ? ST_HALT : ST_REQ);
            ST_DROP: state_d = mem_rsp_valid ? ST_REQ : ST_DROP;
            ST_HALT: state_d = redirect_valid ? ST_REQ : ST_HALT;
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC & ~32'h3;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifu_fifo #(.DEPTH(DEPTH), .W(IFU_ENTRY_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (entry),
        .dout  (head),
        .count (count)
    );

    assign inst_valid = !reset && (count != '0);
    assign inst       = reset ? '0 : head.inst;
    assign inst_pc    = reset ? '0 : head.pc;
    assign inst_fault = !reset && head.fault;
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized scoreboard bench for ifu; memory responder plus a stream-level fetch model.
module tb_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int DEPTH = 2;
`ifdef IFU_PREDECODE_EN
    localparam logic [31:0] JAL_NEXT = 32'h8000_0008;
`else
    localparam logic [31:0] JAL_NEXT = 32'h8000_0004;
`endif
    logic clock = 0, reset = 1, mem_req_ready = 1, mem_rsp_valid = 0, mem_rsp_err = 0;
    logic inst_ready = 0, redirect_valid = 0;
    logic [31:0] mem_rsp_data = 0, redirect_pc = 0;
    logic mem_req_valid, inst_valid, inst_fault;
    logic [31:0] mem_req_addr, inst, inst_pc;

    ifu #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_fault(inst_fault), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] mpc = RESET_PC, fault_addr = 32'h1, jal_addr = 32'h1, prev_addr = 0;
    bit          halted = 0, rand_err = 0, rand_rdy = 0, rand_lat = 0, prev_redir = 0, prev_pend = 0;
    int          checks = 0, errors = 0, lat = 1, fault_pops = 0, pops = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Memory image: pseudo-random ADDI-opcode words, with one address optionally holding jal x0,+8
    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] h = a * 32'h9E37_79B1 ^ 32'h5BD1_E995;
        return (a == jal_addr) ? 32'h0080_006F : {h[31:7], 7'h13};
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        logic [31:0] h = a * 32'h85EB_CA6B;
        return (a == fault_addr) || (rand_err && h[31:27] == 5'd0);
    endfunction

    // Next instruction of the architectural fetch stream starting at mpc
    function automatic exp_t model_next();
        exp_t        e;
        logic [31:0] w = word(mpc);
        logic signed [31:0] imm = 32'(signed'({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        e.pc    = mpc;
        e.fault = is_err(mpc);
        e.inst  = e.fault ? 32'h0000_0013 : w;
        if (e.fault) halted = 1;
`ifdef IFU_PREDECODE_EN
        mpc = (!e.fault && w[6:0] == 7'b1101111) ? mpc + imm : mpc + 32'd4;
`else
        mpc = mpc + 32'd4;
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect(input logic [31:0] a);
        redirect_valid = 1;
        redirect_pc    = a;
        tick();
        redirect_valid = 0;
        req_log.delete();
    endtask

    // Memory responder: one request at a time, configurable latency
    initial begin
        bit          pend = 0;
        int          cnt = 0;
        logic [31:0] pa = 0;
        forever begin
            @(negedge clock);
            if (mem_req_valid && mem_req_ready) begin
                check("one_outstanding", 32'(pend), 0);
                pend = 1;
                pa   = mem_req_addr;
                cnt  = rand_lat ? $urandom_range(1, 4) : lat;
            end
            tick();
            mem_rsp_valid = 0;
            mem_rsp_data  = $urandom;
            mem_rsp_err   = 1'($urandom_range(0, 1));
            if (pend) begin
                if (cnt <= 1) begin
                    mem_rsp_valid = 1;
                    mem_rsp_data  = word(pa);
                    mem_rsp_err   = is_err(pa);
                    pend = 0;
                end else cnt--;
            end
            mem_req_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (mem_req_valid && mem_req_ready) req_log.push_back(mem_req_addr);
            if (reset) begin
                exp_q.delete();
                mpc = RESET_PC;
                halted = 0;
                prev_redir = 0;
                prev_pend = 0;
            end else begin
                if (prev_redir) check("bubble_after_redirect", 32'(inst_valid), 0);
                if (prev_pend) begin
                    check("req_valid_hold", 32'(mem_req_valid), 1);
                    check("req_addr_hold", mem_req_addr, prev_addr);
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    mpc = redirect_pc & ~32'h3;
                    halted = 0;
                end else if (inst_valid && inst_ready) begin
                    if (exp_q.size() == 0 && !halted) exp_q.push_back(model_next());
                    if (exp_q.size() == 0) check("pop_after_fault", 32'(inst_valid), 0);
                    else begin
                        e = exp_q.pop_front();
                        check("inst_pc", inst_pc, e.pc);
                        check("inst", inst, e.inst);
                        check("inst_fault", 32'(inst_fault), 32'(e.fault));
                        if (e.fault) fault_pops++;
                        pops++;
                    end
                end
                prev_redir = redirect_valid;
                prev_pend  = mem_req_valid && !mem_req_ready && !redirect_valid;
                prev_addr  = mem_req_addr;
            end
        end
    end

    initial begin
        int n0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_valid", 32'(mem_req_valid), 0);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_inst_fault", 32'(inst_fault), 0);
        tick();
        reset = 0;
        inst_ready = 1;
        @(negedge clock);
        check("first_req_valid", 32'(mem_req_valid), 1);
        check("first_req_addr", mem_req_addr, RESET_PC);
        repeat (12) tick();
        @(negedge clock);
        check("seq_req0", req_log[0], 32'h8000_0000);
        check("seq_req1", req_log[1], 32'h8000_0004);
        check("seq_req2", req_log[2], 32'h8000_0008);
        tick();
        inst_ready = 0;
        redirect(32'h0000_2000);
        repeat (10) tick();
        @(negedge clock);
        check("stall_req_valid", 32'(mem_req_valid), 0);
        check("stall_req_count", 32'(req_log.size()), DEPTH);
        check("stall_req0", req_log[0], 32'h0000_2000);
        check("stall_req1", req_log[1], 32'h0000_2004);
        check("stall_head_pc", inst_pc, 32'h0000_2000);
        tick();
        inst_ready = 1;
        repeat (10) tick();
        lat = 3;
        redirect(32'h0000_5000);
        for (int i = 0; i < 100 && req_log.size() == 0; i++) @(negedge clock);
        check("wait_req_5000", 32'(req_log.size() > 0), 1);
        tick();
        redirect(32'h0000_1003);
        @(negedge clock);
        check("redir_inst_valid", 32'(inst_valid), 0);
        for (int i = 0; i < 100 && req_log.size() == 0; i++) @(negedge clock);
        check("redir_req_addr", req_log[0], 32'h0000_1000);
        tick();
        lat = 1;
        fault_addr = 32'h8000_0004;
        fault_pops = 0;
        redirect(32'h8000_0000);
        repeat (20) tick();
        @(negedge clock);
        check("halt_req_count", 32'(req_log.size()), 2);
        check("halt_req_valid", 32'(mem_req_valid), 0);
        check("halt_fault_pops", 32'(fault_pops), 1);
        tick();
        fault_addr = 32'h1;
        jal_addr = 32'h8000_0000;
        redirect(32'h8000_0000);
        repeat (8) tick();
        @(negedge clock);
        check("jal_next_req", req_log[1], JAL_NEXT);
        tick();
        jal_addr = 32'h1;
        redirect(32'hFFFF_FFF8);
        repeat (10) tick();
        @(negedge clock);
        check("wrap_req2", req_log[2], 32'h0000_0000);
        check("wrap_req3", req_log[3], 32'h0000_0004);
        n0 = req_log.size();
        for (int i = 0; i < 100 && req_log.size() == n0; i++) @(negedge clock);
        check("wait_req_rst", 32'(req_log.size() > n0), 1);
        tick();
        reset = 1;
        @(negedge clock);
        check("midrst_req_valid", 32'(mem_req_valid), 0);
        check("midrst_inst_valid", 32'(inst_valid), 0);
        tick();
        reset = 0;
        @(negedge clock);
        check("rel_inst_valid", 32'(inst_valid), 0);
        check("rel_req_valid", 32'(mem_req_valid), 1);
        check("rel_req_addr", mem_req_addr, RESET_PC);
        tick();
        rand_err = 1;
        rand_rdy = 1;
        rand_lat = 1;
        redirect(32'h0000_4000);
        n0 = pops;
        repeat (3000) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 63) == 0);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 0;
        repeat (20) tick();
        check("random_progress", 32'(pops - n0 > 200), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
